// File: rtl/string2array_pkg.sv
// Shared SHA3 state geometry: lane-array type, chunk sizing and the string-bit index function.
package string2array_pkg;

   localparam int unsigned X  = 5;
   localparam int unsigned Y  = 5;
   localparam int unsigned Z  = 64;
   localparam int unsigned CW = 200;
   localparam int unsigned NC = 8;
   localparam int unsigned SW = 1600;

   typedef logic [4:0][4:0][63:0] state_t;

   // Position of lane bit (x,y,z) in the flat 1600-bit string
   function automatic logic [10:0] lane_bit(int unsigned x, int unsigned y, int unsigned z);
      return 11'(Z * (X * y + x) + z);
   endfunction

endpackage

// File: rtl/string2array_if.sv
// Chunked input link and reassembled-state output of the string-to-array deserializer.
interface string2array_if;
   import string2array_pkg::*;

   logic          pushin;
   logic [2:0]    dinix;
   logic [CW-1:0] din;
   logic          pushout;
   state_t        dout;
   logic          err;

   modport master (output pushin, dinix, din, input pushout, dout, err);
   modport slave  (input pushin, dinix, din, output pushout, dout, err);

endinterface

// File: rtl/string2array.sv
// Collects eight indexed 200-bit chunks into a 1600-bit string and presents it as a
// 5x5x64 lane array with a one-cycle push strobe; out-of-order chunks drop the frame.
module string2array
   import string2array_pkg::*;
(
   input logic          clk,
   input logic          reset,
   string2array_if.slave s2a
);

   logic [SW-1:0] sacc_q, sacc_d;
   logic [2:0]    nix_q, nix_d;
   state_t        dout_q, dout_d;
   logic          pushout_q, pushout_d;
   logic          err_q, err_d;

   logic [SW-1:0] frame_bits;
   state_t        frame_state;
   logic [10:0]   slot_base;

   // Final chunk bypasses the accumulator so the frame is mapped in the same cycle
   assign frame_bits = {s2a.din, sacc_q[SW-CW-1:0]};
   assign slot_base  = 11'(nix_q) * 11'(CW);

   always_comb begin
      frame_state = '0;
      for (int unsigned x = 0; x < X; x++) begin
         for (int unsigned y = 0; y < Y; y++) begin
            for (int unsigned z = 0; z < Z; z++) begin
               frame_state[x][y][z] = frame_bits[lane_bit(x, y, z)];
            end
         end
      end
   end

   always_comb begin
      sacc_d    = sacc_q;
      nix_d     = nix_q;
      dout_d    = dout_q;
      pushout_d = 1'b0;
      err_d     = 1'b0;
      if (s2a.pushin) begin
         if (s2a.dinix == nix_q) begin
            sacc_d[slot_base +: CW] = s2a.din;
            if (nix_q == 3'(NC - 1)) begin
               dout_d    = frame_state;
               pushout_d = 1'b1;
               nix_d     = 3'd0;
            end else begin
               nix_d = nix_q + 3'd1;
            end
         end else if (s2a.dinix == 3'd0) begin
            // Resynchronise on a fresh chunk 0 rather than losing it
            err_d          = 1'b1;
            sacc_d[0 +: CW] = s2a.din;
            nix_d          = 3'd1;
         end else begin
            err_d = 1'b1;
            nix_d = 3'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sacc_q    <= '0;
         nix_q     <= 3'd0;
         dout_q    <= '0;
         pushout_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sacc_q    <= sacc_d;
         nix_q     <= nix_d;
         dout_q    <= dout_d;
         pushout_q <= pushout_d;
         err_q     <= err_d;
      end
   end

   assign s2a.pushout = pushout_q;
   assign s2a.dout    = dout_q;
   assign s2a.err     = err_q;

endmodule

// File: tb/tb_string2array.sv
// Scoreboard bench for string2array: stimulus queues expected pushout/err events, a monitor
// on the falling edge pops and compares them.
module tb_string2array;
   import string2array_pkg::*;

   typedef struct {
      logic   is_err;
      state_t st;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   string2array_if bus ();

   string2array dut (
      .clk   (clk),
      .reset (reset),
      .s2a   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic state_t rand_state();
      state_t s;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            s[x][y] = {$urandom(), $urandom()};
         end
      end
      return s;
   endfunction

   // Independent model of the flattening: S[64*(5y+x)+z] = A[x][y][z]
   function automatic logic [199:0] chunk_of(state_t s, int k);
      logic [1599:0] str;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            for (int z = 0; z < 64; z++) begin
               str[64 * (5 * y + x) + z] = s[x][y][z];
            end
         end
      end
      return str[200 * k +: 200];
   endfunction

   task automatic send(state_t s, int k, int idx);
      bus.pushin = 1'b1;
      bus.dinix  = 3'(idx);
      bus.din    = chunk_of(s, k);
      @(posedge clk);
      #1;
      bus.pushin = 1'b0;
      bus.dinix  = 3'd0;
      bus.din    = '0;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_frame(state_t s);
      exp_t e;
      e.is_err = 1'b0;
      e.st     = s;
      exp_q.push_back(e);
   endtask

   task automatic expect_err();
      exp_t e;
      e.is_err = 1'b1;
      e.st     = '0;
      exp_q.push_back(e);
   endtask

   // Chunks lo..hi of s, random idle gap of 0..gap_max cycles between them
   task automatic send_range(state_t s, int lo, int hi, int gap_max);
      for (int k = lo; k <= hi; k++) begin
         if (k == 7) expect_frame(s);
         send(s, k, k);
         if (gap_max > 0 && k != hi) idle($urandom_range(gap_max, 0));
      end
   endtask

   always @(negedge clk) begin
      if (reset && (bus.pushout || bus.err)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got pushout=%0b err=%0b, required none", bus.pushout,
                     bus.err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.is_err) begin
               if (!bus.err || bus.pushout) begin
                  errors++;
                  $display("FAIL err_pulse: got pushout=%0b err=%0b, required pushout=0 err=1",
                           bus.pushout, bus.err);
               end
            end else if (!bus.pushout || bus.err || bus.dout !== e.st) begin
               errors++;
               $display("FAIL frame_out: got pushout=%0b err=%0b lane00=%h lane43=%h, required pushout=1 err=0 lane00=%h lane43=%h",
                        bus.pushout, bus.err, bus.dout[0][0], bus.dout[4][3], e.st[0][0],
                        e.st[4][3]);
            end
         end
      end
   end

   task automatic check_idle_zero(string name);
      checks++;
      if (bus.pushout !== 1'b0 || bus.err !== 1'b0 || bus.dout !== '0) begin
         errors++;
         $display("FAIL %s: got pushout=%0b err=%0b dout_nonzero=%0b, required all zero", name,
                  bus.pushout, bus.err, (bus.dout != '0));
      end
   endtask

   initial begin
      state_t a, b, c, d, e, junk;
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      bus.pushin = 1'b0;
      bus.dinix  = 3'd0;
      bus.din    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset_state");
      reset = 1'b1;
      idle(2);

      // Contiguous frame
      a = rand_state();
      send_range(a, 0, 7, 0);
      idle(3);

      // Random gaps between chunks
      a = rand_state();
      send_range(a, 0, 7, 5);
      idle(3);

      // Back-to-back frames
      a = rand_state();
      b = rand_state();
      send_range(a, 0, 7, 0);
      send_range(b, 0, 7, 0);
      idle(3);

      // Wrong non-zero index drops frame and discards chunk
      c = rand_state();
      junk = rand_state();
      send_range(junk, 0, 2, 0);
      expect_err();
      send(junk, 5, 5);
      send_range(c, 0, 7, 1);
      idle(3);

      // Unexpected index 0 restarts the frame with that chunk kept
      d = rand_state();
      junk = rand_state();
      send_range(junk, 0, 3, 0);
      expect_err();
      send(d, 0, 0);
      send_range(d, 1, 7, 0);
      idle(3);

      // Asynchronous reset mid-frame
      e = rand_state();
      junk = rand_state();
      send_range(junk, 0, 4, 0);
      #2;
      reset = 1'b0;
      #1;
      check_idle_zero("reset_midframe");
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1);
      // First chunk after reset must be index 0
      expect_err();
      send(junk, 5, 5);
      send_range(e, 0, 7, 0);
      idle(3);

      // Stream of random frames, as an array2string source would emit them
      for (int n = 0; n < 20; n++) begin
         a = rand_state();
         send_range(a, 0, 7, (n % 3 == 0) ? 2 : 0);
      end
      idle(5);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending events, required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
